wam_mole: RTL and testbench

//  Whack-a-mole front end: spawns moles in 8 holes from an LFSR, times each mole's exposure, and

---
 rtl/wam_mole_pkg.sv | 28 ++
 rtl/wam_mole_hole.sv | 87 ++++++++
 rtl/wam_mole.sv | 93 +++++++++
 tb/tb_wam_mole.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wam_mole_pkg.sv
// Shared definitions for the whack-a-mole front end.
// Hole states, LFSR taps and small combinational helpers.
package wam_mole_pkg;

  localparam int HOLES = 8;

  // Galois mask for taps 16,14,13,11 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    COOL = 2'd2
  } hole_st_t;

  function automatic logic [HOLES-1:0] lowest_one(
    input logic [HOLES-1:0] v
  );
    return v & (~v + HOLES'(1));
  endfunction

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/wam_mole_hole.sv
// One hole: IDLE/UP/COOL state machine with a tick-based timer.
// Reports a hit or a timeout as single-cycle combinational events.
module wam_hole
  import wam_mole_pkg::*;
#(
  parameter int COOL_TICKS = 200
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic        spawn,
  input  logic        press,
  input  logic        tick,
  input  logic [15:0] life,
  output logic        mol,
  output logic        hit_evt,
  output logic        miss_evt
);

  localparam logic [15:0] COOL_LD = 16'(COOL_TICKS);

  hole_st_t    st, st_n;
  logic [15:0] tm, tm_n;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st <= IDLE;
      tm <= '0;
    end else begin
      st <= st_n;
      tm <= tm_n;
    end
  end

  always_comb begin
    st_n     = st;
    tm_n     = tm;
    hit_evt  = 1'b0;
    miss_evt = 1'b0;
    if (!en) begin
      st_n = IDLE;
      tm_n = '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (spawn) begin
            st_n = UP;
            tm_n = life;
          end
        end
        UP: begin
          // a press beats a same-cycle timeout
          if (press) begin
            st_n    = COOL;
            tm_n    = COOL_LD;
            hit_evt = 1'b1;
          end else if (tick) begin
            if (tm <= 16'd1) begin
              st_n     = COOL;
              tm_n     = COOL_LD;
              miss_evt = 1'b1;
            end else begin
              tm_n = tm - 16'd1;
            end
          end
        end
        COOL: begin
          if (tick) begin
            if (tm <= 16'd1) begin
              st_n = IDLE;
              tm_n = '0;
            end else begin
              tm_n = tm - 16'd1;
            end
          end
        end
        default: begin
          st_n = IDLE;
          tm_n = '0;
        end
      endcase
    end
  end

  assign mol = (st == UP);

endmodule

// File: rtl/wam_mole.sv
// Whack-a-mole front end: tick divider, LFSR spawner, level
// tracking, eight hole FSMs and a one-hot hit serializer.
module wam_mole
  import wam_mole_pkg::*;
#(
  parameter int          TICK_DIV   = 50000,
  parameter int          UP_TICKS   = 1000,
  parameter int          COOL_TICKS = 200,
  parameter int          SPAWN_GAP  = 300,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [HOLES-1:0] btn,
  input  logic             lvl_up,
  output logic [HOLES-1:0] mol,
  output logic [HOLES-1:0] hit,
  output logic             miss,
  output logic [1:0]       level
);

  logic [31:0]      div;
  logic [15:0]      spc;
  logic [15:0]      lfsr;
  logic [HOLES-1:0] btn_q;
  logic [2:0]       lsync;
  logic [HOLES-1:0] pend;

  logic             tick;
  logic             spawn_try;
  logic             lvl_rise;
  logic [HOLES-1:0] press;
  logic [HOLES-1:0] issue;
  logic [HOLES-1:0] hit_evt;
  logic [HOLES-1:0] miss_evt;
  logic [15:0]      life_raw;
  logic [15:0]      life;

  assign tick      = (div == 32'(TICK_DIV - 1));
  assign spawn_try = tick && en
                  && (spc == 16'(SPAWN_GAP - 1));
  assign press     = btn & ~btn_q;
  assign lvl_rise  = lsync[1] & ~lsync[2];
  assign life_raw  = 16'(UP_TICKS) >> level;
  assign life      = (life_raw == '0) ? 16'd1 : life_raw;
  // forced gap after every pulse keeps edges distinct
  assign issue     = (hit == '0) ? lowest_one(pend) : '0;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      div   <= '0;
      spc   <= '0;
      lfsr  <= LFSR_SEED;
      btn_q <= '0;
      lsync <= '0;
      level <= '0;
      pend  <= '0;
      hit   <= '0;
      miss  <= 1'b0;
    end else begin
      div   <= tick ? '0 : div + 32'd1;
      lfsr  <= lfsr_next(lfsr);
      btn_q <= btn;
      lsync <= {lsync[1:0], lvl_up};
      if (tick && en)
        spc <= spawn_try ? '0 : spc + 16'd1;
      if (lvl_rise && level != 2'd3)
        level <= level + 2'd1;
      pend  <= (pend & ~issue) | hit_evt;
      hit   <= issue;
      miss  <= |miss_evt;
    end
  end

  for (genvar i = 0; i < HOLES; i++) begin : g_hole
    wam_hole #(
      .COOL_TICKS(COOL_TICKS)
    ) u_hole (
      .clk     (clk),
      .clr     (clr),
      .en      (en),
      .spawn   (spawn_try && lfsr[2:0] == 3'(i)),
      .press   (press[i]),
      .tick    (tick),
      .life    (life),
      .mol     (mol[i]),
      .hit_evt (hit_evt[i]),
      .miss_evt(miss_evt[i])
    );
  end

endmodule

// File: tb/tb_wam_mole.sv
// Directed and random checks of wam_mole against a
// tick-counting reference model of the game rules.
module tb_wam_mole;

  localparam int TD  = 4;
  localparam int UT  = 8;
  localparam int CT  = 2;
  localparam int GAP = 2;

  logic       clk;
  logic       clr;
  logic       en;
  logic [7:0] btn;
  logic       lvl_up;
  logic [7:0] mol;
  logic [7:0] hit;
  logic       miss;
  logic [1:0] level;

  wam_mole #(
    .TICK_DIV  (TD),
    .UP_TICKS  (UT),
    .COOL_TICKS(CT),
    .SPAWN_GAP (GAP),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .clk   (clk),
    .clr   (clr),
    .en    (en),
    .btn   (btn),
    .lvl_up(lvl_up),
    .mol   (mol),
    .hit   (hit),
    .miss  (miss),
    .level (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // reference model: ticks remaining per hole, 0 = not in phase
  int          m_div;
  int          m_enticks;
  logic [15:0] m_lfsr;
  logic [7:0]  m_btnq;
  int          m_up   [8];
  int          m_cool [8];
  logic [7:0]  m_pend;
  logic [7:0]  m_hit;
  logic        m_miss;
  int          m_level;
  bit          hist   [3];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, got, exp);
    end
  endtask

  function automatic logic [7:0] m_mol();
    logic [7:0] r = '0;
    for (int i = 0; i < 8; i++) r[i] = (m_up[i] > 0);
    return r;
  endfunction

  task automatic model_reset();
    m_div = 0;
    m_enticks = 0;
    m_lfsr = 16'hACE1;
    m_btnq = '0;
    m_pend = '0;
    m_hit = '0;
    m_miss = 1'b0;
    m_level = 0;
    for (int i = 0; i < 3; i++) hist[i] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      m_up[i] = 0;
      m_cool[i] = 0;
    end
  endtask

  task automatic model_step();
    bit         tk;
    bit         att;
    int         tgt;
    int         life;
    logic [7:0] pr;
    logic [7:0] hits;
    bit         anymiss;
    logic [7:0] iss;
    tk   = (m_div == TD - 1);
    att  = tk && en && (m_enticks % GAP == GAP - 1);
    tgt  = int'(m_lfsr[2:0]);
    pr   = btn & ~m_btnq;
    life = UT >> m_level;
    if (life < 1) life = 1;
    hits = '0;
    anymiss = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!en) begin
        m_up[i] = 0;
        m_cool[i] = 0;
      end else if (m_up[i] > 0) begin
        if (pr[i]) begin
          m_up[i] = 0;
          m_cool[i] = CT;
          hits[i] = 1'b1;
        end else if (tk) begin
          m_up[i]--;
          if (m_up[i] == 0) begin
            m_cool[i] = CT;
            anymiss = 1'b1;
          end
        end
      end else if (m_cool[i] > 0) begin
        if (tk) m_cool[i]--;
      end else if (att && tgt == i) begin
        m_up[i] = life;
      end
    end
    iss = '0;
    if (m_hit == '0) begin
      for (int j = 7; j >= 0; j--)
        if (m_pend[j]) iss = 8'(1 << j);
    end
    m_pend = (m_pend & ~iss) | hits;
    m_hit  = iss;
    m_miss = anymiss;
    if (hist[1] && !hist[2] && m_level < 3) m_level++;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = lvl_up;
    m_btnq = btn;
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400)
                       : (m_lfsr >> 1);
    if (tk && en) m_enticks++;
    m_div = tk ? 0 : m_div + 1;
  endtask

  task automatic check_all();
    chk("mol", 32'(mol), 32'(m_mol()));
    chk("hit", 32'(hit), 32'(m_hit));
    chk("miss", 32'(miss), 32'(m_miss));
    chk("level", 32'(level), 32'(m_level));
    chk("lfsr", 32'(dut.lfsr), 32'(m_lfsr));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  bit         found;
  int         cnt;
  int         score;
  int         spawns;
  int         sel;
  logic [7:0] mask;
  logic [7:0] prev;
  logic [7:0] nowm;

  initial begin
    n_chk = 0;
    n_fail = 0;
    clr = 1'b1;
    en = 1'b0;
    btn = '0;
    lvl_up = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    clr = 1'b0;
    chk("rst_mol", 32'(mol), 32'h0);
    chk("rst_hit", 32'(hit), 32'h0);
    chk("rst_miss", 32'(miss), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_lfsr", 32'(dut.lfsr), 32'hACE1);
    en = 1'b1;

    // hit on hole 3
    found = 0;
    for (int k = 0; k < 3000; k++) begin
      if (m_up[3] > 0) begin found = 1; break; end
      cyc();
    end
    chk("wait_h3", 32'(found), 32'h1);
    btn[3] = 1'b1;
    cyc();
    chk("h3_pend", 32'(dut.pend[3]), 32'h1);
    chk("h3_moldrop", 32'(mol[3]), 32'h0);
    chk("h3_hit0", 32'(hit), 32'h0);
    cyc();
    chk("h3_hit", 32'(hit), 32'h08);
    btn = '0;
    cnt = 0;
    for (int k = 0; k < TD; k++) begin
      cyc();
      if (mol[3]) cnt++;
    end
    chk("h3_cool", 32'(cnt), 32'h0);

    // untouched mole on hole 5 times out
    found = 0;
    prev = m_mol();
    for (int k = 0; k < 3000; k++) begin
      cyc();
      if (!prev[5] && mol[5]) begin found = 1; break; end
      prev = m_mol();
    end
    chk("wait_h5", 32'(found), 32'h1);
    cnt = 0;
    for (int k = 0; k < 100 && mol[5]; k++) begin
      cnt++;
      cyc();
    end
    chk("h5_life", 32'(cnt), 32'(UT * TD));
    chk("h5_miss", 32'(miss), 32'h1);
    chk("h5_nohit", 32'(hit), 32'h0);

    // press lands on the timeout tick
    found = 0;
    sel = 0;
    for (int k = 0; k < 3000 && !found; k++) begin
      for (int i = 0; i < 8; i++)
        if (!found && m_up[i] == 1 && m_div == TD - 1) begin
          found = 1;
          sel = i;
        end
      if (!found) cyc();
    end
    chk("wait_tie", 32'(found), 32'h1);
    btn = 8'(1 << sel);
    cyc();
    chk("tie_nomiss", 32'(miss), 32'h0);
    cyc();
    chk("tie_hit", 32'(hit), 32'(1 << sel));
    btn = '0;

    // three or more simultaneous presses serialize
    found = 0;
    for (int k = 0; k < 5000; k++) begin
      if ($countones(m_mol()) >= 3) begin found = 1; break; end
      cyc();
    end
    chk("wait_multi", 32'(found), 32'h1);
    mask = m_mol();
    btn = mask;
    cyc();
    btn = '0;
    chk("ser_first", 32'(hit), 32'h0);
    score = 0;
    cnt = 0;
    for (int j = 0; j < 8; j++) begin
      if (mask[j]) begin
        if (cnt > 0) begin
          cyc();
          chk("ser_gap", 32'(hit), 32'h0);
        end
        cyc();
        chk("ser_bit", 32'(hit), 32'(1 << j));
        score += $countones(hit);
        cnt++;
      end
    end
    chk("ser_score", 32'(score), 32'($countones(mask)));

    // press on an empty hole is ignored
    sel = 0;
    for (int i = 7; i >= 0; i--)
      if (m_up[i] == 0 && m_cool[i] == 0) sel = i;
    btn = 8'(1 << sel);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (hit != '0) cnt++;
    end
    chk("empty_press", 32'(cnt), 32'h0);
    btn = '0;
    cyc();

    // holding btn[2] across two spawns gives one hit
    found = 0;
    for (int k = 0; k < 5000; k++) begin
      if (m_up[2] > 0) begin found = 1; break; end
      cyc();
    end
    chk("wait_h2", 32'(found), 32'h1);
    btn[2] = 1'b1;
    cnt = 0;
    spawns = 0;
    prev = m_mol();
    for (int k = 0; k < 8000 && spawns < 1; k++) begin
      cyc();
      if (hit[2]) cnt++;
      nowm = m_mol();
      if (!prev[2] && nowm[2]) spawns++;
      prev = nowm;
    end
    chk("h2_respawn", 32'(spawns), 32'h1);
    for (int k = 0; k < 3 * TD; k++) begin
      cyc();
      if (hit[2]) cnt++;
    end
    chk("h2_onehit", 32'(cnt), 32'h1);
    btn = '0;
    cyc();

    // dropping en clears moles but queued hits still drain
    found = 0;
    for (int k = 0; k < 5000; k++) begin
      if ($countones(m_mol()) >= 2) begin found = 1; break; end
      cyc();
    end
    chk("wait_en", 32'(found), 32'h1);
    mask = m_mol();
    btn = mask;
    cyc();
    btn = '0;
    en = 1'b0;
    cyc();
    chk("en_mol", 32'(mol), 32'h0);
    score = $countones(hit);
    for (int k = 0; k < 2 * $countones(mask); k++) begin
      cyc();
      score += $countones(hit);
    end
    chk("en_drain", 32'(score), 32'($countones(mask)));
    en = 1'b1;

    // level steps and saturation
    for (int p = 0; p < 4; p++) begin
      lvl_up = 1'b1;
      repeat (3) cyc();
      lvl_up = 1'b0;
      repeat (4) cyc();
      chk("level_step", 32'(level), 32'((p < 3) ? p + 1 : 3));
    end
    found = 0;
    sel = 0;
    prev = m_mol();
    for (int k = 0; k < 3000 && !found; k++) begin
      cyc();
      nowm = m_mol() & ~prev;
      for (int i = 0; i < 8; i++)
        if (nowm[i]) begin found = 1; sel = i; end
      prev = m_mol();
    end
    chk("wait_fast", 32'(found), 32'h1);
    cnt = 0;
    for (int k = 0; k < 100 && mol[sel]; k++) begin
      cnt++;
      cyc();
    end
    chk("fast_life", 32'(cnt), 32'(TD));

    // random play
    for (int k = 0; k < 3000; k++) begin
      btn = btn ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      en = ($urandom_range(0, 39) != 0);
      cyc();
    end

    // asynchronous clear mid-game
    en = 1'b1;
    for (int k = 0; k < 200; k++) begin
      btn = btn ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      cyc();
    end
    #2;
    clr = 1'b1;
    #1;
    chk("clr_mol", 32'(mol), 32'h0);
    chk("clr_hit", 32'(hit), 32'h0);
    chk("clr_miss", 32'(miss), 32'h0);
    chk("clr_level", 32'(level), 32'h0);
    btn = '0;
    lvl_up = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    clr = 1'b0;
    chk("clr_lfsr", 32'(dut.lfsr), 32'hACE1);

    // random play with level-ups from reset
    for (int k = 0; k < 2000; k++) begin
      btn = btn ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      en = ($urandom_range(0, 39) != 0);
      lvl_up = ($urandom_range(0, 149) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
